// File: rtl/proc_pkg.sv
// Shared definitions for the memory bus arbiter.
//   - arbiter state encodings (IDLE / ACCESS / RESP)
//   - grant owner encodings (CPU / external port)
//   - default address and data widths
package proc_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } arb_owner_t;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/arb_wait_cnt.sv
// Loadable 4-bit down-counter that paces memory wait states.
// Ports:
//   clk        - system clock, rising edge
//   clr        - asynchronous active-low reset (count returns to 0)
//   i_load     - load i_load_val (has priority over i_en)
//   i_en       - decrement by one; holds at zero
//   i_load_val - value loaded on i_load
//   o_zero     - high while the count is zero
module arb_wait_cnt (
  input  logic       clk,
  input  logic       clr,
  input  logic       i_load,
  input  logic       i_en,
  input  logic [3:0] i_load_val,
  output logic       o_zero
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_zero = (r_cnt == 4'd0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory port between the processor core and an
// external requester (loader/debug/DMA). Each access is granted in IDLE,
// runs WAIT_CYC+1 cycles in ACCESS, and is acknowledged for one cycle in RESP.
// Ports:
//   clk, clr                           - clock, asynchronous active-low reset
//   cpu_req/rw/addr/wdata              - core request (held until cpu_ack)
//   cpu_rdata, cpu_ack                 - core read data, completion pulse
//   cpu_hold                           - combinational stall to the core sequencer
//   ext_req/rw/addr/wdata              - external request (held until ext_ack)
//   ext_rdata, ext_ack                 - external read data, completion pulse
//   mem_en/rw/addr/wdata, mem_rdata    - memory macro interface
module mem_bus_arbiter
  import proc_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int WAIT_CYC       = 0,
  parameter int MAX_CPU_STREAK = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_hold,
  input  logic              ext_req,
  input  logic              ext_rw,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_ack,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] LP_WAIT       = 4'(WAIT_CYC);
  localparam logic [3:0] LP_MAX_STREAK = 4'(MAX_CPU_STREAK);

  arb_state_t        r_state, w_state_nxt;
  arb_owner_t        r_owner, w_owner_nxt;
  logic [3:0]        r_streak, w_streak_nxt;
  logic              r_mem_en, w_mem_en_nxt;
  logic              r_mem_rw, w_mem_rw_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [DATA_W-1:0] r_cpu_rdata, w_cpu_rdata_nxt;
  logic [DATA_W-1:0] r_ext_rdata, w_ext_rdata_nxt;
  logic              r_cpu_ack, w_cpu_ack_nxt;
  logic              r_ext_ack, w_ext_ack_nxt;

  logic w_wait_load, w_wait_en, w_wait_zero;
  logic w_any_req, w_win_ext;

  arb_wait_cnt u_wait_cnt (
    .clk        (clk),
    .clr        (clr),
    .i_load     (w_wait_load),
    .i_en       (w_wait_en),
    .i_load_val (LP_WAIT),
    .o_zero     (w_wait_zero)
  );

  // External port wins when alone, or when the CPU has used up its streak.
  assign w_any_req = cpu_req | ext_req;
  assign w_win_ext = ext_req & (~cpu_req | (r_streak == LP_MAX_STREAK));

  // State and registered outputs
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state     <= ARB_IDLE;
      r_owner     <= OWN_CPU;
      r_streak    <= 4'd0;
      r_mem_en    <= 1'b0;
      r_mem_rw    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_rdata <= '0;
      r_ext_rdata <= '0;
      r_cpu_ack   <= 1'b0;
      r_ext_ack   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_streak    <= w_streak_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_mem_rw    <= w_mem_rw_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_cpu_rdata <= w_cpu_rdata_nxt;
      r_ext_rdata <= w_ext_rdata_nxt;
      r_cpu_ack   <= w_cpu_ack_nxt;
      r_ext_ack   <= w_ext_ack_nxt;
    end
  end

  // Next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE:   if (w_any_req) w_state_nxt = ARB_ACCESS;
      ARB_ACCESS: if (w_wait_zero) w_state_nxt = ARB_RESP;
      ARB_RESP:   w_state_nxt = ARB_IDLE;  // never re-grant from RESP
      default:    w_state_nxt = ARB_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    w_owner_nxt     = r_owner;
    w_streak_nxt    = r_streak;
    w_mem_en_nxt    = r_mem_en;
    w_mem_rw_nxt    = r_mem_rw;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_cpu_rdata_nxt = r_cpu_rdata;
    w_ext_rdata_nxt = r_ext_rdata;
    w_cpu_ack_nxt   = 1'b0;
    w_ext_ack_nxt   = 1'b0;
    w_wait_load     = 1'b0;
    w_wait_en       = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        w_mem_en_nxt = 1'b0;
        if (w_any_req) begin
          w_mem_en_nxt = 1'b1;
          w_wait_load  = 1'b1;
          if (w_win_ext) begin
            w_owner_nxt     = OWN_EXT;
            w_mem_rw_nxt    = ext_rw;
            w_mem_addr_nxt  = ext_addr;
            w_mem_wdata_nxt = ext_wdata;
            w_streak_nxt    = 4'd0;
          end else begin
            w_owner_nxt     = OWN_CPU;
            w_mem_rw_nxt    = cpu_rw;
            w_mem_addr_nxt  = cpu_addr;
            w_mem_wdata_nxt = cpu_wdata;
            // Only contended CPU grants count toward the streak.
            if (!ext_req) begin
              w_streak_nxt = 4'd0;
            end else if (r_streak != 4'hF) begin
              w_streak_nxt = r_streak + 4'd1;
            end
          end
        end
      end
      ARB_ACCESS: begin
        if (!w_wait_zero) begin
          w_wait_en = 1'b1;
        end else begin
          w_mem_en_nxt = 1'b0;
          if (r_owner == OWN_EXT) begin
            w_ext_ack_nxt = 1'b1;
            if (!r_mem_rw) w_ext_rdata_nxt = mem_rdata;
          end else begin
            w_cpu_ack_nxt = 1'b1;
            if (!r_mem_rw) w_cpu_rdata_nxt = mem_rdata;
          end
        end
      end
      default: ;
    endcase
  end

  assign mem_en    = r_mem_en;
  assign mem_rw    = r_mem_rw;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_rdata = r_cpu_rdata;
  assign ext_rdata = r_ext_rdata;
  assign cpu_ack   = r_cpu_ack;
  assign ext_ack   = r_ext_ack;
  assign cpu_hold  = cpu_req & ~r_cpu_ack;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single program/data memory port between the processor core (fetch, load, output writes) and an external requester (loader/debug/DMA).
- Sequences each access through programmable wait states and returns a registered acknowledge.
- Drives a hold signal that freezes the core's fetch/decode/execute/increment sequencer while the core's access is pending.
- Sits between the core control/datapath and the memory macro.

Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width
- WAIT_CYC, 0, extra memory wait cycles per access (0..15)
- MAX_CPU_STREAK, 4, consecutive contended CPU grants allowed before the external port is forced a grant (1..15)

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  asynchronous active-low reset
- cpu_req  in  1  core access request; held until cpu_ack
- cpu_rw  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  core address
- cpu_wdata  in  DATA_W  core write data
- cpu_rdata  out  DATA_W  last core read data, registered
- cpu_ack  out  1  one-cycle completion pulse to the core
- cpu_hold  out  1  stall to the core sequencer; = cpu_req & ~cpu_ack
- ext_req  in  1  external access request; held until ext_ack
- ext_rw  in  1  1 = write, 0 = read
- ext_addr  in  ADDR_W  external address
- ext_wdata  in  DATA_W  external write data
- ext_rdata  out  DATA_W  last external read data, registered
- ext_ack  out  1  one-cycle completion pulse to the external port
- mem_en  out  1  memory access strobe
- mem_rw  out  1  memory write enable (1 = write)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid in the last ACCESS cycle

Behaviour:
- Reset (clr=0, asynchronous):
  - state=IDLE; mem_en=0, mem_rw=0, mem_addr=0, mem_wdata=0.
  - cpu_ack=ext_ack=0; cpu_rdata=ext_rdata=0.
  - streak counter=0, wait counter=0, grant owner=CPU.
  - Reset mid-access aborts the access: no ack is issued, and the requester must re-request after reset.
- States are IDLE, ACCESS and RESP. All outputs except cpu_hold are registered.
- IDLE:
  - Request sampling: at each rising edge, if either request is high, pick a winner and latch its rw/addr/wdata into the mem_* registers.
  - On a grant: set mem_en=1, load wait counter with WAIT_CYC, go to ACCESS.
  - No request: stay in IDLE with mem_en=0.
- Arbitration (IDLE only):
  - A single requester always wins.
  - Both requesting: the CPU wins unless streak==MAX_CPU_STREAK, in which case the external port wins.
  - A CPU grant with ext_req high increments streak (saturating).
  - A CPU grant with ext_req low, or any external grant, clears streak.
- ACCESS:
  - mem_en=1; mem_addr, mem_wdata and mem_rw are held stable for the whole access.
  - If wait counter != 0: decrement and stay.
  - If wait counter == 0:
    - Read: capture mem_rdata into the winner's rdata register only.
    - Clear mem_en, set the winner's ack, go to RESP.
- RESP:
  - Winner's ack=1 for exactly one cycle; the winner's rdata register is valid.
  - The next state is always IDLE; requests are not sampled in RESP, so there is no back-to-back re-grant on a stale req.
  - The requester drops req during its ack cycle, or re-raises it for a new access.
- Latency: request seen at IDLE edge k, ack high in cycle k+WAIT_CYC+2. Minimum 3 cycles per access.
- Writes update neither rdata register.
- cpu_hold is combinational: high while cpu_req=1 and cpu_ack=0. The core sequencer advances only when cpu_hold=0.
- A request that drops before its grant is ignored. A request that drops after its grant does not cancel the access; the ack is still issued.
- The non-granted requester's ack stays 0 throughout.
- Inputs are assumed synchronous to clk; no internal synchronizers are required.

Decomposition:
- Shared package proc_pkg holds:
  - state encodings ARB_IDLE/ARB_ACCESS/ARB_RESP (2-bit)
  - owner encodings OWN_CPU/OWN_EXT
  - default ADDR_W/DATA_W
- One sub-module, arb_wait_cnt: a loadable 4-bit down-counter with load, enable and zero-flag outputs.
- The arbitration logic and streak counter stay inline.

Test Plan:
- Reset then CPU read: WAIT_CYC=0, mem holds 0x5A at 0x10; cpu_req with addr 0x10 → mem_en high 1 cycle with mem_addr=0x10, cpu_ack 2 cycles after the sampling edge, cpu_rdata=0x5A, ext_ack=0.
- Wait states: WAIT_CYC=3, ext write 0xC3 to 0x20 → mem_en high 4 cycles, mem_rw=1, addr/data stable, ext_ack at k+5, mem[0x20]=0xC3, ext_rdata unchanged.
- Contention fairness: MAX_CPU_STREAK=2, both requesting continuously, WAIT_CYC=0 → grant order CPU, CPU, EXT, CPU, CPU, EXT; no two acks ever in the same cycle.
- Hold: cpu_req asserted while EXT is in ACCESS → cpu_hold=1 until cpu_ack, dropping in the ack cycle; the core sequencer state is frozen meanwhile.
- Reset mid-access: clr low in the 2nd ACCESS cycle (WAIT_CYC=3) → mem_en and both acks go 0 immediately, state=IDLE, rdata=0, no ack after release until a new request.
- Stale request: the requester keeps req high through RESP → exactly one ack per access; the next grant is sampled only in the following IDLE cycle.
